// File: rtl/rtc_bcd_cfg_if.sv
// rtc_bcd_cfg_if: control and display bundle of the BCD real-time clock.
// master drives controls and reads the display, slave is the clock core.
interface rtc_bcd_cfg_if;
  logic        en;
  logic        mode_12h;
  logic        ld;
  logic [23:0] ld_time;
  logic        ld_pm;
  logic        alm_set;
  logic [15:0] alm_time;
  logic        alm_clr;
  logic [3:0]  sl, sm, ml, mm, hl, hm;
  logic        pm;
  logic        sec_tick;
  logic        day_wrap;
  logic        ld_err;
  logic        alarm;

  modport master (
    output en, mode_12h, ld, ld_time, ld_pm,
    output alm_set, alm_time, alm_clr,
    input  sl, sm, ml, mm, hl, hm,
    input  pm, sec_tick, day_wrap, ld_err, alarm
  );

  modport slave (
    input  en, mode_12h, ld, ld_time, ld_pm,
    input  alm_set, alm_time, alm_clr,
    output sl, sm, ml, mm, hl, hm,
    output pm, sec_tick, day_wrap, ld_err, alarm
  );
endinterface

// File: rtl/rtc_bcd_cfg.sv
// rtc_bcd_cfg: BCD hh:mm:ss clock, 24 h or 12 h AM/PM, validated load.
// Define ALARM_EN to build the hh:mm alarm compare and sticky flag.
module rtc_bcd_cfg #(
  parameter int TICK_DIV = 50_000_000
) (
  input logic          clk,
  input logic          rst,
  rtc_bcd_cfg_if.slave bus
);
  localparam int PS_W = $clog2(TICK_DIV + 1);
  localparam logic [PS_W-1:0] PS_TOP = PS_W'(TICK_DIV - 1);

  function automatic logic [6:0] hbin(input logic [7:0] hh);
    return 7'(hh[7:4]) * 7'd10 + 7'(hh[3:0]);
  endfunction

  function automatic logic [7:0] hbcd(input logic [6:0] h);
    logic [3:0] d;
    d = (h >= 7'd20) ? 4'd2 : (h >= 7'd10) ? 4'd1 : 4'd0;
    return {d, 4'(h - 7'(d) * 7'd10)};
  endfunction

  // {mm,ml,sm,sl}: tens digits 0-5, units 0-9
  function automatic logic ok_ms(input logic [15:0] v);
    return v[15:12] <= 4'd5 && v[11:8] <= 4'd9 &&
           v[7:4] <= 4'd5 && v[3:0] <= 4'd9;
  endfunction

  function automatic logic ok_hd(input logic [7:0] hh);
    return hh[7:4] <= 4'd2 && hh[3:0] <= 4'd9;
  endfunction

  logic [PS_W-1:0] ps, ps_n;
  logic [23:0]     tm, tm_n, adv;
  logic            pm, pm_n, adv_pm;
  logic            cur_12h;
  logic            tick, tick_n;
  logic            wrap, wrap_n, adv_wrap;
  logic            err, err_n;
  logic [6:0]      h_cur, h_nxt, h_cv, ld_h;
  logic            tick_raw, mode_edge, ld_ok;

  assign h_cur     = hbin(tm[23:16]);
  assign ld_h      = hbin(bus.ld_time[23:16]);
  assign tick_raw  = bus.en && (ps == PS_TOP);
  assign mode_edge = bus.mode_12h != cur_12h;
  assign ld_ok     = ok_ms(bus.ld_time[15:0]) &&
                     ok_hd(bus.ld_time[23:16]) &&
                     (bus.mode_12h ? (ld_h >= 7'd1 && ld_h <= 7'd12)
                                   : (ld_h <= 7'd23));

  // one-second advance of the displayed time with BCD carry chain
  always_comb begin
    adv      = tm;
    adv_pm   = pm;
    adv_wrap = 1'b0;
    h_nxt    = h_cur;
    if (tm[3:0] != 4'd9) begin
      adv[3:0] = tm[3:0] + 4'd1;
    end else begin
      adv[3:0] = 4'd0;
      if (tm[7:4] != 4'd5) begin
        adv[7:4] = tm[7:4] + 4'd1;
      end else begin
        adv[7:4] = 4'd0;
        if (tm[11:8] != 4'd9) begin
          adv[11:8] = tm[11:8] + 4'd1;
        end else begin
          adv[11:8] = 4'd0;
          if (tm[15:12] != 4'd5) begin
            adv[15:12] = tm[15:12] + 4'd1;
          end else begin
            adv[15:12] = 4'd0;
            if (cur_12h) begin
              unique case (1'b1)
                h_cur == 7'd11: begin
                  h_nxt    = 7'd12;
                  adv_pm   = ~pm;
                  adv_wrap = pm;
                end
                h_cur == 7'd12: h_nxt = 7'd1;
                default:        h_nxt = h_cur + 7'd1;
              endcase
            end else begin
              if (h_cur == 7'd23) begin
                h_nxt    = 7'd0;
                adv_wrap = 1'b1;
              end else begin
                h_nxt = h_cur + 7'd1;
              end
              adv_pm = h_nxt >= 7'd12;
            end
            adv[23:16] = hbcd(h_nxt);
          end
        end
      end
    end
  end

  // hour rewrite on a mode change; pm already means "afternoon" in both modes
  always_comb begin
    h_cv = h_cur;
    if (bus.mode_12h) begin
      unique case (1'b1)
        h_cur == 7'd0: h_cv = 7'd12;
        h_cur > 7'd12: h_cv = h_cur - 7'd12;
        default:       h_cv = h_cur;
      endcase
    end else begin
      unique case (1'b1)
        pm && h_cur != 7'd12:  h_cv = h_cur + 7'd12;
        !pm && h_cur == 7'd12: h_cv = 7'd0;
        default:               h_cv = h_cur;
      endcase
    end
  end

  // next state: load beats mode conversion beats tick
  always_comb begin
    ps_n   = ps;
    tm_n   = tm;
    pm_n   = pm;
    tick_n = 1'b0;
    wrap_n = 1'b0;
    err_n  = 1'b0;
    if (bus.ld && ld_ok) begin
      tm_n = bus.ld_time;
      pm_n = bus.mode_12h ? bus.ld_pm : (ld_h >= 7'd12);
      ps_n = '0;
    end else if (mode_edge) begin
      err_n        = bus.ld;
      tm_n[23:16]  = hbcd(h_cv);
      if (bus.en && !tick_raw) ps_n = ps + PS_W'(1);
    end else begin
      err_n = bus.ld;
      if (tick_raw) begin
        ps_n   = '0;
        tm_n   = adv;
        pm_n   = adv_pm;
        tick_n = 1'b1;
        wrap_n = adv_wrap;
      end else if (bus.en) begin
        ps_n = ps + PS_W'(1);
      end
    end
  end

  // time, prescaler and strobe registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ps      <= '0;
      tm      <= bus.mode_12h ? 24'h120000 : 24'h000000;
      pm      <= 1'b0;
      cur_12h <= bus.mode_12h;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else begin
      ps      <= ps_n;
      tm      <= tm_n;
      pm      <= pm_n;
      cur_12h <= bus.mode_12h;
      tick    <= tick_n;
      wrap    <= wrap_n;
      err     <= err_n;
    end
  end

  assign bus.hm       = tm[23:20];
  assign bus.hl       = tm[19:16];
  assign bus.mm       = tm[15:12];
  assign bus.ml       = tm[11:8];
  assign bus.sm       = tm[7:4];
  assign bus.sl       = tm[3:0];
  assign bus.pm       = pm;
  assign bus.sec_tick = tick;
  assign bus.day_wrap = wrap;
  assign bus.ld_err   = err;

`ifdef ALARM_EN
  logic [15:0] alm;
  logic        alm_flag;
  logic [6:0]  adv_h, adv_h24;
  logic        alm_ok, hit;

  assign adv_h  = hbin(adv[23:16]);
  assign alm_ok = ok_ms({bus.alm_time[7:0], 8'h00}) &&
                  ok_hd(bus.alm_time[15:8]) &&
                  hbin(bus.alm_time[15:8]) <= 7'd23;

  // new time as a 24 h hour for the alarm compare
  always_comb begin
    adv_h24 = adv_h;
    if (cur_12h) begin
      if (adv_pm) adv_h24 = (adv_h == 7'd12) ? 7'd12 : adv_h + 7'd12;
      else        adv_h24 = (adv_h == 7'd12) ? 7'd0 : adv_h;
    end
  end

  assign hit = tick_n && adv_h24 == hbin(alm[15:8]) &&
               adv[15:0] == {alm[7:0], 8'h00};

  // alarm time register and sticky flag; clear wins over a match
  always_ff @(posedge clk) begin
    if (!rst) begin
      alm      <= 16'h0000;
      alm_flag <= 1'b0;
    end else begin
      if (bus.alm_set && alm_ok) alm <= bus.alm_time;
      if (bus.alm_clr)           alm_flag <= 1'b0;
      else if (hit)              alm_flag <= 1'b1;
    end
  end

  assign bus.alarm = alm_flag;
`else
  assign bus.alarm = 1'b0;
`endif
endmodule

// File: tb/tb_rtc_bcd_cfg.sv
// tb_rtc_bcd_cfg: directed plus random stimulus against a
// seconds-of-day reference model of the BCD clock.
module tb_rtc_bcd_cfg;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rtc_bcd_cfg_if bus();
  rtc_bcd_cfg #(.TICK_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  int m_secs, m_ps, m_alm;
  bit m_mode, m_tick, m_wrap, m_err, m_alarm;

  // BCD time to seconds of day, -1 when not a legal value in that mode
  function automatic int parse(logic [23:0] t, bit m12, bit p);
    int hm = t[23:20];
    int hl = t[19:16];
    int mm = t[15:12];
    int ml = t[11:8];
    int sm = t[7:4];
    int sl = t[3:0];
    int h;
    if (hl > 9 || ml > 9 || sl > 9 || mm > 5 || sm > 5 || hm > 9)
      return -1;
    h = hm * 10 + hl;
    if (m12) begin
      if (h < 1 || h > 12) return -1;
      h = (h % 12) + (p ? 12 : 0);
    end else if (h > 23) begin
      return -1;
    end
    return h * 3600 + (mm * 10 + ml) * 60 + sm * 10 + sl;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  v;
    bit  medge, tr;
    if (!rst) begin
      m_secs = 0; m_ps = 0; m_alm = 0;
      m_tick = 0; m_wrap = 0; m_err = 0; m_alarm = 0;
      m_mode = bus.mode_12h;
      return;
    end
    medge  = bus.mode_12h != m_mode;
    tr     = bus.en && m_ps == 3;
    m_tick = 0;
    m_wrap = 0;
    m_err  = 0;
    v = bus.ld ? parse(bus.ld_time, bus.mode_12h, bus.ld_pm) : -1;
    if (v >= 0) begin
      m_secs = v;
      m_ps   = 0;
    end else begin
      m_err = bus.ld;
      if (medge) begin
        if (bus.en && !tr) m_ps++;
      end else if (tr) begin
        m_ps   = 0;
        m_secs = (m_secs + 1) % 86400;
        m_tick = 1;
        m_wrap = (m_secs == 0);
      end else if (bus.en) begin
        m_ps++;
      end
    end
    m_mode = bus.mode_12h;
`ifdef ALARM_EN
    if (bus.alm_clr) m_alarm = 0;
    else if (m_tick && m_secs == m_alm) m_alarm = 1;
    if (bus.alm_set) begin
      v = parse({bus.alm_time, 8'h00}, 0, 0);
      if (v >= 0) m_alm = v;
    end
`endif
  endtask

  task automatic check_all();
    int h24, hd, mn, sc;
    h24 = m_secs / 3600;
    mn  = (m_secs / 60) % 60;
    sc  = m_secs % 60;
    hd  = m_mode ? ((h24 % 12 == 0) ? 12 : h24 % 12) : h24;
    chk("hm", bus.hm, hd / 10);
    chk("hl", bus.hl, hd % 10);
    chk("mm", bus.mm, mn / 10);
    chk("ml", bus.ml, mn % 10);
    chk("sm", bus.sm, sc / 10);
    chk("sl", bus.sl, sc % 10);
    chk("pm", bus.pm, h24 >= 12);
    chk("sec_tick", bus.sec_tick, m_tick);
    chk("day_wrap", bus.day_wrap, m_wrap);
    chk("ld_err", bus.ld_err, m_err);
    chk("alarm", bus.alarm, m_alarm);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic load(logic [23:0] t, bit p);
    bus.ld      = 1'b1;
    bus.ld_time = t;
    bus.ld_pm   = p;
    cyc();
    bus.ld = 1'b0;
  endtask

  task automatic expect_time(string tag, logic [23:0] t, bit p);
    chk(tag, {bus.hm, bus.hl, bus.mm, bus.ml, bus.sm, bus.sl}, t);
    chk({tag, "_pm"}, bus.pm, p);
  endtask

  function automatic logic [23:0] rnd_time(bit m12);
    int h, m, s;
    logic [23:0] t;
    h = $urandom_range(0, 23);
    m = $urandom_range(0, 59);
    s = $urandom_range(0, 59);
    if ($urandom_range(0, 2) == 0) begin
      m = 59;
      s = $urandom_range(50, 59);
    end
    if ($urandom_range(0, 3) == 0) h = m12 ? 11 : 23;
    if (m12) h = (h % 12 == 0) ? 12 : h % 12;
    t = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
         4'(s / 10), 4'(s % 10)};
    if ($urandom_range(0, 5) == 0) t = 24'($urandom());
    return t;
  endfunction

  function automatic logic [15:0] rnd_alm();
    int mi;
    mi = (m_secs / 60 + 1) % 1440;
    if ($urandom_range(0, 3) == 0) mi = $urandom_range(0, 1439);
    if ($urandom_range(0, 7) == 0) return 16'($urandom());
    return {4'((mi / 60) / 10), 4'((mi / 60) % 10),
            4'((mi % 60) / 10), 4'((mi % 60) % 10)};
  endfunction

  initial begin
    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.mode_12h = 1'b0;
    bus.ld       = 1'b0;
    bus.ld_time  = '0;
    bus.ld_pm    = 1'b0;
    bus.alm_set  = 1'b0;
    bus.alm_time = '0;
    bus.alm_clr  = 1'b0;
    cyc();
    cyc();
    expect_time("reset24", 24'h000000, 1'b0);

    rst    = 1'b1;
    bus.en = 1'b1;
    repeat (40) cyc();
    expect_time("count40", 24'h000010, 1'b0);

    load(24'h235958, 1'b0);
    repeat (8) cyc();
    expect_time("wrap24", 24'h000000, 1'b0);
    chk("wrap24_strobe", bus.day_wrap, 1'b1);

    bus.mode_12h = 1'b1;
    cyc();
    load(24'h115959, 1'b1);
    repeat (4) cyc();
    expect_time("wrap12", 24'h120000, 1'b0);
    chk("wrap12_strobe", bus.day_wrap, 1'b1);

    load(24'h125959, 1'b0);
    repeat (4) cyc();
    expect_time("h12to1", 24'h010000, 1'b0);
    chk("h12to1_nowrap", bus.day_wrap, 1'b0);

    load(24'h001000, 1'b0);
    expect_time("inv12", 24'h010000, 1'b0);
    chk("inv12_err", bus.ld_err, 1'b1);

    bus.mode_12h = 1'b0;
    cyc();
    load(24'h240000, 1'b0);
    expect_time("inv24", 24'h010000, 1'b0);
    chk("inv24_err", bus.ld_err, 1'b1);

    load(24'h123456, 1'b0);
    repeat (3) cyc();
    load(24'h050505, 1'b0);
    repeat (3) cyc();
    expect_time("ld_ps3_hold", 24'h050505, 1'b0);
    cyc();
    expect_time("ld_ps3_tick", 24'h050506, 1'b0);
    chk("ld_ps3_stb", bus.sec_tick, 1'b1);

    bus.en = 1'b0;
    load(24'h153020, 1'b0);
    bus.mode_12h = 1'b1;
    cyc();
    expect_time("to12", 24'h033020, 1'b1);
    bus.mode_12h = 1'b0;
    cyc();
    expect_time("to24", 24'h153020, 1'b1);
    bus.en = 1'b1;

`ifdef ALARM_EN
    bus.alm_set  = 1'b1;
    bus.alm_time = 16'h0700;
    cyc();
    bus.alm_set = 1'b0;
    load(24'h065958, 1'b0);
    repeat (8) cyc();
    expect_time("alm_hit", 24'h070000, 1'b0);
    chk("alm_set", bus.alarm, 1'b1);
    load(24'h065959, 1'b0);
    repeat (3) cyc();
    bus.alm_clr = 1'b1;
    cyc();
    bus.alm_clr = 1'b0;
    chk("alm_clr_wins", bus.alarm, 1'b0);
`endif

    repeat (2) cyc();
    rst          = 1'b0;
    bus.mode_12h = 1'b1;
    cyc();
    expect_time("reset12", 24'h120000, 1'b0);
    chk("reset12_tick", bus.sec_tick, 1'b0);
    rst = 1'b1;
    repeat (4) cyc();
    expect_time("post_rst", 24'h120001, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      bus.en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) bus.mode_12h = ~bus.mode_12h;
      bus.ld       = ($urandom_range(0, 19) == 0);
      bus.ld_time  = rnd_time(bus.mode_12h);
      bus.ld_pm    = 1'($urandom_range(0, 1));
      bus.alm_set  = ($urandom_range(0, 49) == 0);
      bus.alm_time = rnd_alm();
      bus.alm_clr  = ($urandom_range(0, 29) == 0);
      rst          = ($urandom_range(0, 499) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
